// File: rtl/ow_frame_sequencer_if.sv
// ow_frame_sequencer_if: byte-stream, transmit and register-port signals
// between the 1-Wire front end / register bank and the frame sequencer.
// master: front end + register bank side. slave: the sequencer.
interface ow_frame_sequencer_if;
    logic       frame_start;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       tx_req;
    logic [7:0] tx_byte;
    logic       tx_ack;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic [7:0] reg_rdata;
    logic       busy;
    logic       done;
    logic       err;
    logic [1:0] err_code;

    modport master (
        output frame_start, rx_valid, rx_byte, tx_ack, reg_rdata,
        input  tx_req, tx_byte, reg_we, reg_re, reg_addr, reg_wdata,
               busy, done, err, err_code
    );

    modport slave (
        input  frame_start, rx_valid, rx_byte, tx_ack, reg_rdata,
        output tx_req, tx_byte, reg_we, reg_re, reg_addr, reg_wdata,
               busy, done, err, err_code
    );
endinterface

// File: rtl/ow_frame_sequencer.sv
// ow_frame_sequencer: parses the RW/quantity/address header from the 1-Wire
// byte stream and runs register writes or fetch-and-transmit reads.
// Optional feature macro OW_SEQ_CRC_EN: header CRC8 byte check and a trailing
// CRC8 byte after read data.
//
// state     | meaning
// IDLE      | no frame, waiting for frame_start
// HDR0      | waiting for RW/quantity byte
// HDR1      | waiting for start address byte
// CRC_CHK   | waiting for header CRC byte (CRC build only)
// WR_DATA   | one register write per received byte
// RD_FETCH  | issue reg_re at current address
// RD_WAIT   | read strobe in flight
// RD_CAP    | read data valid, load tx_byte and raise tx_req
// RD_SEND   | holding tx_req until tx_ack
// CRC_TX    | transmitting CRC of sent data (CRC build only)
// DONE      | frame finished, done pulse
// ERR       | abort, error flag set
module ow_frame_sequencer #(
    parameter int TIMEOUT_CYCLES = 30000,
    parameter int CNT_W          = 16
) (
    input logic           clk,
    input logic           rst_n,
    ow_frame_sequencer_if.slave bus
);

`ifdef OW_SEQ_CRC_EN
    typedef enum logic [3:0] {
        S_IDLE, S_HDR0, S_HDR1, S_CRC_CHK, S_WR_DATA, S_RD_FETCH,
        S_RD_WAIT, S_RD_CAP, S_RD_SEND, S_CRC_TX, S_DONE, S_ERR
    } state_t;
`else
    typedef enum logic [3:0] {
        S_IDLE, S_HDR0, S_HDR1, S_WR_DATA, S_RD_FETCH,
        S_RD_WAIT, S_RD_CAP, S_RD_SEND, S_DONE, S_ERR
    } state_t;
`endif

    state_t           r_state;
    logic             r_rw;
    logic [6:0]       r_qty;
    logic [7:0]       r_addr;
    logic [CNT_W-1:0] r_tmo;
    logic             r_tx_req;
    logic [7:0]       r_tx_byte;
    logic             r_reg_we;
    logic             r_reg_re;
    logic [7:0]       r_reg_addr;
    logic [7:0]       r_reg_wdata;
    logic             r_done;
    logic             r_err;
    logic [1:0]       r_err_code;
`ifdef OW_SEQ_CRC_EN
    logic [7:0]       r_crc;
`endif

    logic w_cnt_en;
    logic w_tmo_hit;
    logic w_rd_phase;

    function automatic state_t dispatch(input logic rw, input logic [6:0] qty);
        if (qty == 7'd0) return S_DONE;
        return rw ? S_RD_FETCH : S_WR_DATA;
    endfunction

`ifdef OW_SEQ_CRC_EN
    // Dallas/Maxim CRC8, reflected polynomial 0x8C, LSB first.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) c = (c >> 1) ^ 8'h8C;
            else                c = c >> 1;
        end
        return c;
    endfunction
`endif

    assign w_cnt_en   = (r_state == S_HDR0) || (r_state == S_HDR1) ||
`ifdef OW_SEQ_CRC_EN
                        (r_state == S_CRC_CHK) ||
`endif
                        (r_state == S_WR_DATA) || (r_state == S_RD_SEND);
    assign w_tmo_hit  = (r_tmo == CNT_W'(TIMEOUT_CYCLES - 1));
    assign w_rd_phase = (r_state == S_RD_FETCH) || (r_state == S_RD_WAIT) ||
`ifdef OW_SEQ_CRC_EN
                        (r_state == S_CRC_TX) ||
`endif
                        (r_state == S_RD_CAP) || (r_state == S_RD_SEND);

    assign bus.tx_req    = r_tx_req;
    assign bus.tx_byte   = r_tx_byte;
    assign bus.reg_we    = r_reg_we;
    assign bus.reg_re    = r_reg_re;
    assign bus.reg_addr  = r_reg_addr;
    assign bus.reg_wdata = r_reg_wdata;
    assign bus.done      = r_done;
    assign bus.err       = r_err;
    assign bus.err_code  = r_err_code;
    assign bus.busy      = (r_state != S_IDLE) && (r_state != S_DONE) && (r_state != S_ERR);

    // Frame sequencing FSM with registered strobes, tx handshake and error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_rw        <= 1'b0;
            r_qty       <= '0;
            r_addr      <= '0;
            r_tmo       <= '0;
            r_tx_req    <= 1'b0;
            r_tx_byte   <= '0;
            r_reg_we    <= 1'b0;
            r_reg_re    <= 1'b0;
            r_reg_addr  <= '0;
            r_reg_wdata <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_err_code  <= '0;
`ifdef OW_SEQ_CRC_EN
            r_crc       <= '0;
`endif
        end else begin
            r_reg_we <= 1'b0;
            r_reg_re <= 1'b0;
            r_done   <= 1'b0;
            // Every state change in a counting state is caused by rx_valid or
            // tx_ack, and non-counting states hold the counter at zero, so this
            // also clears the counter on state entry.
            r_tmo <= (w_cnt_en && !bus.rx_valid && !bus.tx_ack) ? r_tmo + CNT_W'(1) : '0;

            if (bus.frame_start) begin
                r_state    <= S_HDR0;
                r_err      <= 1'b0;
                r_err_code <= 2'd0;
                r_tx_req   <= 1'b0;
                r_tmo      <= '0;
`ifdef OW_SEQ_CRC_EN
                r_crc      <= '0;
`endif
            end else if (w_cnt_en && w_tmo_hit && !bus.rx_valid && !bus.tx_ack) begin
                r_state    <= S_ERR;
                r_err      <= 1'b1;
                r_err_code <= 2'd1;
                r_tx_req   <= 1'b0;
            end else if (w_rd_phase && bus.rx_valid) begin
                r_state    <= S_ERR;
                r_err      <= 1'b1;
                r_err_code <= 2'd2;
                r_tx_req   <= 1'b0;
            end else begin
                case (r_state)
                    S_HDR0: if (bus.rx_valid) begin
                        r_rw    <= bus.rx_byte[7];
                        r_qty   <= bus.rx_byte[6:0];
`ifdef OW_SEQ_CRC_EN
                        r_crc   <= crc8_step(r_crc, bus.rx_byte);
`endif
                        r_state <= S_HDR1;
                    end
                    S_HDR1: if (bus.rx_valid) begin
                        r_addr  <= bus.rx_byte;
`ifdef OW_SEQ_CRC_EN
                        r_crc   <= crc8_step(r_crc, bus.rx_byte);
                        r_state <= S_CRC_CHK;
`else
                        r_state <= dispatch(r_rw, r_qty);
`endif
                    end
`ifdef OW_SEQ_CRC_EN
                    S_CRC_CHK: if (bus.rx_valid) begin
                        if (bus.rx_byte == r_crc) begin
                            // Reuse the CRC register for the read-data trailer.
                            r_crc   <= '0;
                            r_state <= dispatch(r_rw, r_qty);
                        end else begin
                            r_state    <= S_ERR;
                            r_err      <= 1'b1;
                            r_err_code <= 2'd3;
                        end
                    end
`endif
                    S_WR_DATA: if (bus.rx_valid) begin
                        r_reg_we    <= 1'b1;
                        r_reg_addr  <= r_addr;
                        r_reg_wdata <= bus.rx_byte;
                        r_addr      <= r_addr + 8'd1;
                        r_qty       <= r_qty - 7'd1;
                        if (r_qty == 7'd1) r_state <= S_DONE;
                    end
                    S_RD_FETCH: begin
                        r_reg_re   <= 1'b1;
                        r_reg_addr <= r_addr;
                        r_state    <= S_RD_WAIT;
                    end
                    S_RD_WAIT: r_state <= S_RD_CAP;
                    S_RD_CAP: begin
                        r_tx_byte <= bus.reg_rdata;
                        r_tx_req  <= 1'b1;
`ifdef OW_SEQ_CRC_EN
                        r_crc     <= crc8_step(r_crc, bus.reg_rdata);
`endif
                        r_state   <= S_RD_SEND;
                    end
                    S_RD_SEND: if (bus.tx_ack) begin
                        r_tx_req <= 1'b0;
                        r_addr   <= r_addr + 8'd1;
                        r_qty    <= r_qty - 7'd1;
                        if (r_qty == 7'd1) begin
`ifdef OW_SEQ_CRC_EN
                            r_state <= S_CRC_TX;
`else
                            // done follows the last ack directly; DONE sees it set.
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
`endif
                        end else begin
                            r_state <= S_RD_FETCH;
                        end
                    end
`ifdef OW_SEQ_CRC_EN
                    S_CRC_TX: begin
                        if (!r_tx_req) begin
                            r_tx_req  <= 1'b1;
                            r_tx_byte <= r_crc;
                        end else if (bus.tx_ack) begin
                            r_tx_req <= 1'b0;
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end
                    end
`endif
                    // Read frames enter with done already pulsing; others pulse it here.
                    S_DONE: begin
                        r_done  <= ~r_done;
                        r_state <= S_IDLE;
                    end
                    S_ERR:   r_state <= S_IDLE;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ow_frame_sequencer.sv
// tb_ow_frame_sequencer: directed and randomized frames against a queue/array
// reference model of the register bank and expected transfers.
module tb_ow_frame_sequencer;
    localparam int TMO = 30000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ow_frame_sequencer_if bus();

    ow_frame_sequencer #(.TIMEOUT_CYCLES(TMO), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int last_rx_cyc = 0, last_re_cyc = 0, last_we_cyc = 0, done_cyc = 0;
    int we_cnt = 0, re_cnt = 0, done_cnt = 0;
    logic [15:0] q_wr[$];
    logic [7:0]  mdl[256];
    logic [7:0]  bank[256];
    logic [7:0]  wr_data[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] crc_of(input logic [7:0] bytes[$]);
        logic [7:0] c;
        logic fb;
        c = 8'h00;
        foreach (bytes[i])
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ bytes[i][b];
                c = c >> 1;
                if (fb) c = c ^ 8'h8C;
            end
        return c;
    endfunction

    // Register bank model on the DUT's register port (one-cycle read latency).
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) bank[i] <= 8'(i * 7 + 3);
        end else begin
            if (bus.reg_we) bank[bus.reg_addr] <= bus.reg_wdata;
            if (bus.reg_re) bus.reg_rdata <= bank[bus.reg_addr];
        end
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: records strobes and checks write latency.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (bus.reg_we) begin
                we_cnt++;
                q_wr.push_back({bus.reg_addr, bus.reg_wdata});
                last_we_cyc = cyc;
                chk("we_lat", cyc, last_rx_cyc + 1);
            end
            if (bus.rx_valid) last_rx_cyc = cyc;
            if (bus.reg_re) begin
                re_cnt++;
                last_re_cyc = cyc;
            end
            if (bus.done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    initial begin
        #(200000 * 10);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_byte  = b;
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic fs();
        bus.frame_start = 1'b1;
        @(posedge clk); #1;
        bus.frame_start = 1'b0;
    endtask

    task automatic ack();
        bus.tx_ack = 1'b1;
        @(posedge clk); #1;
        bus.tx_ack = 1'b0;
    endtask

    task automatic send_hdr(input logic rw, input logic [6:0] qty, input logic [7:0] addr);
        logic [7:0] hq[$];
        fs();
        idle($urandom_range(0, 2));
        send({rw, qty});
        idle($urandom_range(0, 2));
        send(addr);
`ifdef OW_SEQ_CRC_EN
        hq.push_back({rw, qty});
        hq.push_back(addr);
        idle($urandom_range(0, 2));
        send(crc_of(hq));
`endif
    endtask

    task automatic wait_done(input string tag, input int d0);
        for (int k = 0; k < 40; k++) begin
            if (done_cnt > d0) break;
            @(posedge clk); #1;
        end
        chk(tag, 32'(done_cnt > d0), 1);
    endtask

    task automatic wait_tx(output logic ok);
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (bus.tx_req) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("tx_req_seen", 32'(ok), 1);
    endtask

    // Write frame of wr_data.size() bytes starting at addr.
    task automatic write_frame(input logic [7:0] addr);
        int we0, d0, qty;
        logic [15:0] got;
        we0 = we_cnt;
        d0  = done_cnt;
        qty = wr_data.size();
        q_wr.delete();
        send_hdr(1'b0, 7'(qty), addr);
        for (int i = 0; i < qty; i++) begin
            idle($urandom_range(0, 3));
            send(wr_data[i]);
            mdl[8'(addr + 8'(i))] = wr_data[i];
        end
        wait_done("wr_done", d0);
        idle(2);
        chk("wr_done_once", done_cnt - d0, 1);
        chk("wr_count", we_cnt - we0, qty);
        for (int i = 0; i < qty; i++) begin
            got = (q_wr.size() > 0) ? q_wr.pop_front() : 16'hxxxx;
            chk("wr_addr", got[15:8], 8'(addr + 8'(i)));
            chk("wr_data", got[7:0], wr_data[i]);
        end
        if (qty > 0) chk("wr_done_lat", done_cyc, last_we_cyc + 1);
        chk("wr_err", bus.err, 0);
    endtask

    task automatic read_frame(input logic [7:0] addr, input int qty);
        int d0, ack_cyc;
        logic ok;
        logic [7:0] held;
        logic [7:0] sent[$];
        d0 = done_cnt;
        ack_cyc = 0;
        send_hdr(1'b1, 7'(qty), addr);
        for (int i = 0; i < qty; i++) begin
            wait_tx(ok);
            if (!ok) return;
            chk("rd_lat", cyc, last_re_cyc + 2);
            chk("rd_data", bus.tx_byte, mdl[8'(addr + 8'(i))]);
            held = bus.tx_byte;
            sent.push_back(mdl[8'(addr + 8'(i))]);
            idle($urandom_range(0, 3));
            chk("rd_hold", {bus.tx_req, bus.tx_byte}, {1'b1, held});
            ack_cyc = cyc;
            ack();
        end
`ifdef OW_SEQ_CRC_EN
        if (qty > 0) begin
            wait_tx(ok);
            if (!ok) return;
            chk("rd_crc", bus.tx_byte, crc_of(sent));
            ack_cyc = cyc;
            ack();
        end
`endif
        wait_done("rd_done", d0);
        if (qty > 0) chk("rd_done_lat", done_cyc, ack_cyc + 1);
        idle(2);
        chk("rd_done_once", done_cnt - d0, 1);
        chk("rd_err", bus.err, 0);
    endtask

    initial begin
        logic ok;
        int we0, re0, d0;
        logic [7:0] a;
        bus.frame_start = 1'b0;
        bus.rx_valid    = 1'b0;
        bus.rx_byte     = 8'h00;
        bus.tx_ack      = 1'b0;
        for (int i = 0; i < 256; i++) mdl[i] = 8'(i * 7 + 3);

        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("rst_out", {bus.tx_req, bus.reg_we, bus.reg_re, bus.done, bus.err, bus.busy}, 0);
        chk("rst_code", bus.err_code, 0);
        chk("rst_bytes", {bus.tx_byte, bus.reg_addr, bus.reg_wdata}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(4);
        @(posedge clk); #1;

        // Basic write frame.
        wr_data = '{8'hA1, 8'hB2, 8'hC3};
        write_frame(8'h10);

        // Load 0xFF/0x00 through a wrapping write, then read back across the wrap.
        wr_data = '{8'h5A, 8'h3C};
        write_frame(8'hFF);
        read_frame(8'hFF, 2);

        // tx_ack with no pending tx_req is ignored.
        d0 = done_cnt;
        ack();
        idle(3);
        chk("stray_ack", {bus.tx_req, bus.busy, bus.err}, 0);
        chk("stray_ack_done", done_cnt - d0, 0);

        // Inter-byte timeout.
        we0 = we_cnt;
        send_hdr(1'b0, 7'd5, 8'h20);
        idle(TMO - 20);
        chk("tmo_early", bus.err, 0);
        idle(60);
        chk("tmo_err", {bus.err, bus.err_code}, {1'b1, 2'd1});
        chk("tmo_no_we", we_cnt - we0, 0);
        chk("tmo_busy", bus.busy, 0);

        // rx byte during the read phase.
        send_hdr(1'b1, 7'd1, 8'h00);
        wait_tx(ok);
        send(8'h77);
        idle(1);
        chk("proto_err", {bus.err, bus.err_code}, {1'b1, 2'd2});
        chk("proto_txreq", bus.tx_req, 0);
        re0 = re_cnt;
        idle(5);
        chk("proto_no_re", re_cnt - re0, 0);
        fs();
        idle(1);
        chk("proto_clear", {bus.err, bus.err_code}, 0);

        // Abort a write after one of three data bytes.
        we0 = we_cnt;
        q_wr.delete();
        send_hdr(1'b0, 7'd3, 8'h40);
        send(8'hD0);
        mdl[8'h40] = 8'hD0;
        idle(1);
        fs();
        idle(2);
        chk("abort_we", we_cnt - we0, 1);
        chk("abort_wr", (q_wr.size() > 0) ? q_wr[0] : 16'hxxxx, 16'h40D0);
        chk("abort_busy", bus.busy, 1);
        wr_data = '{8'hE1, 8'hE2};
        write_frame(8'h50);

`ifdef OW_SEQ_CRC_EN
        // Wrong header CRC, then a correct frame.
        we0 = we_cnt;
        fs();
        send(8'h01);
        send(8'h10);
        send(8'h00 ^ crc_of('{8'h01, 8'h10}) ^ 8'h5C);
        idle(2);
        chk("crc_err", {bus.err, bus.err_code}, {1'b1, 2'd3});
        chk("crc_no_we", we_cnt - we0, 0);
        wr_data = '{8'h99};
        write_frame(8'h10);
`endif

        // Randomized frames, including zero-length and address wrap.
        for (int f = 0; f < 40; f++) begin
            a = ($urandom_range(0, 3) == 0) ? 8'(8'hFC + $urandom_range(0, 3)) : 8'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                read_frame(a, $urandom_range(0, 5));
            end else begin
                wr_data.delete();
                for (int i = 0, n = $urandom_range(0, 5); i < n; i++) wr_data.push_back(8'($urandom));
                write_frame(a);
            end
            idle($urandom_range(0, 4));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/ow_frame_sequencer.md
# ow_frame_sequencer

Transaction sequencer behind the 1-Wire slave byte receiver. Parses the two-byte control header (RW, 7-bit quantity, 8-bit start address) from the received byte stream, then drives an 8-bit register-file port: consecutive writes for write frames, or fetch-and-transmit for read frames through the slave's transmit handshake. Sits between the 1-Wire bit/byte front end and the application register bank.

## Interface
- TIMEOUT_CYCLES, 30000: maximum idle cycles between bytes in an active frame before abort.
- CNT_W, 16: width of the inter-byte timeout counter.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- frame_start  in  1  one-cycle pulse from the front end after a completed presence pulse.
- rx_valid  in  1  one-cycle pulse; rx_byte holds a received byte.
- rx_byte  in  8  received byte, LSB first on the wire, presented parallel.
- tx_req  out  1  byte ready for the front end to transmit.
- tx_byte  out  8  byte to transmit; stable while tx_req=1.
- tx_ack  in  1  front end has latched tx_byte.
- reg_we  out  1  register write strobe, one cycle.
- reg_re  out  1  register read strobe, one cycle.
- reg_addr  out  8  register address.
- reg_wdata  out  8  write data.
- reg_rdata  in  8  read data, valid the cycle after reg_re.
- busy  out  1  frame in progress (state not IDLE/DONE/ERR).
- done  out  1  one-cycle pulse on successful frame end.
- err  out  1  sticky error flag; cleared by frame_start.
- err_code  out  2  0 none, 1 timeout, 2 protocol (rx byte during read phase), 3 CRC mismatch.

## Operation
- Reset: all outputs 0, state IDLE, counters 0.
- IDLE: wait for frame_start -> HDR0.
- HDR0: on rx_valid latch rw=rx_byte[7], qty=rx_byte[6:0] -> HDR1.
- HDR1: on rx_valid latch addr=rx_byte -> CRC_CHK if OW_SEQ_CRC_EN, else dispatch.
- Dispatch: qty==0 -> DONE; rw=0 -> WR_DATA; rw=1 -> RD_FETCH.
- WR_DATA: on rx_valid assert reg_we with reg_addr=addr, reg_wdata=rx_byte same cycle+1 (registered); addr+=1, qty-=1; qty reaches 0 -> DONE.
- RD_FETCH: pulse reg_re at addr -> RD_WAIT (1 cycle) -> capture reg_rdata into tx_byte, raise tx_req -> RD_SEND.
- RD_SEND: hold tx_req until tx_ack; on ack drop tx_req, addr+=1, qty-=1; qty 0 -> DONE (or CRC_TX), else RD_FETCH.
- DONE: pulse done one cycle -> IDLE.
- ERR: set err/err_code, deassert tx_req, no further reg strobes; -> IDLE.
- Address arithmetic 8-bit, wraps 0xFF -> 0x00 without error.
- Timeout counter resets on every rx_valid/tx_ack and on state entry; counts in HDR0, HDR1, CRC_CHK, WR_DATA, RD_SEND; reaching TIMEOUT_CYCLES -> ERR code 1.
- rx_valid in RD_FETCH/RD_WAIT/RD_SEND -> ERR code 2.
- frame_start in any state aborts current frame, clears err/err_code, drops tx_req, -> HDR0. Takes priority over rx_valid same cycle.

## Timing
- Write: reg_we asserted exactly 1 cycle after the data rx_valid.
- Read: reg_re 1 cycle after entering RD_FETCH; tx_req rises 2 cycles after reg_re.
- done asserted 1 cycle after the last reg_we or last tx_ack.
- tx_ack without tx_req ignored.

## Configuration
- OW_SEQ_CRC_EN defined: third header byte is Dallas CRC8 (x^8+x^5+x^4+1, init 0, LSB first) of bytes 0-1; mismatch -> ERR code 3, no register access. Read frames append one tx byte: CRC8 of all sent data (CRC_TX state) before DONE.
- Undefined: header is two bytes, no CRC states, err_code 3 never produced.

## Test plan
- Write frame 0x03,0x10,0xA1,0xB2,0xC3 -> reg_we at addr 0x10/0x11/0x12 with 0xA1/0xB2/0xC3, done pulse, err=0.
- Read frame 0x82,0xFF with regs[0xFF]=0x5A, regs[0x00]=0x3C -> tx bytes 0x5A then 0x3C (address wrap), done.
- Header 0x05,0x20 then silence TIMEOUT_CYCLES -> err=1, err_code=1, no reg_we.
- Read frame 0x81,0x00, inject rx_valid during RD_SEND -> err_code=2, tx_req dropped; next frame_start clears err.
- frame_start mid-write after 1 of 3 data bytes -> exactly one reg_we, state HDR0, new frame completes normally.
- With OW_SEQ_CRC_EN: header 0x01,0x10 plus wrong CRC -> err_code=3, no reg_we; correct CRC -> write proceeds.
